regfile_access_ctrl: RTL and testbench
======================================

// Module: regfile_access_ctrl
// PURPOSE
//  Initiator side of the RegFile port set (2 read, 1 write). Clears every register after reset.
//  Accepts operand-read requests (valid/ready) and returns both operands one cycle later.
//  Forwards same-cycle and stalled-cycle writebacks so returned operands are always current.
//  Sits between decode (requests), writeback (writes) and the RegFile instance.
// PARAMETERS
//  ADSize   5   register address width
//  REGSize  32  number of registers; init sequence covers 0..REGSize-1
//  DASize   32  data width
//  ZERO_R0  0   1: reads of addr 0 return 0 and writes to addr 0 are dropped
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  init_done  out  1       1 once the clear sequence has finished
//  req_valid  in   1       operand-read request
//  req_ready  out  1       request accepted when req_valid && req_ready
//  req_rs1    in   ADSize  source address 1
//  req_rs2    in   ADSize  source address 2
//  wb_valid   in   1       writeback strobe (no backpressure)
//  wb_rd      in   ADSize  writeback address
//  wb_data    in   DASize  writeback data
//  rsp_valid  out  1       operands valid
//  rsp_ready  in   1       consumer takes the response when rsp_valid && rsp_ready
//  rsp_op1    out  DASize  operand for rs1
//  rsp_op2    out  DASize  operand for rs2
//  rf_we      out  1       to RegFile RegWrite
//  rf_raddr1  out  ADSize  to RegFile Read_ADDR_1
//  rf_raddr2  out  ADSize  to RegFile Read_ADDR_2
//  rf_waddr   out  ADSize  to RegFile Write_ADDR
//  rf_din     out  DASize  to RegFile DIN
//  rf_out1    in   DASize  from RegFile OUT_1 (combinational read)
//  rf_out2    in   DASize  from RegFile OUT_2 (combinational read)
// BEHAVIOUR
//  - RegFile contract: combinational read; write on posedge clk when rf_we=1.
//  - Reset values: state=INIT, init_cnt=0, init_done=0, rsp_valid=0, rsp_op1=0, rsp_op2=0.
//  - Reset is a plain synchronous input: asserting rst mid-operation drops any held response
//    (rsp_valid=0 next cycle) and restarts INIT.
//  - FSM INIT: rf_we=1, rf_waddr=init_cnt, rf_din=0, init_cnt increments each cycle.
//      - Leaves to RUN after the cycle that writes REGSize-1 (exactly REGSize cycles).
//      - req_ready=0 throughout INIT; wb_valid is ignored.
//  - FSM RUN: terminal until rst; init_done=1.
//      - rf_we=wb_valid (0 when ZERO_R0=1 and wb_rd=0); rf_waddr=wb_rd; rf_din=wb_data.
//  - req_ready = RUN && (!rsp_valid || rsp_ready)   (single output register, no skid).
//  - rf_raddr1/2 = req_rs1/2 at all times in RUN; 0 in INIT.
//  - Accept (1-cycle latency): on the accept edge, rsp_opN <= fwd(rsN).
//      - fwd(a) = 0 if ZERO_R0 && a==0;
//      - else wb_data if wb_valid && wb_rd==a;
//      - else rf_outN.
//    The held rs1/rs2 addresses are registered with the operands.
//  - rsp_valid: set on accept; cleared on rsp_ready && no new accept; stays 1 on back-to-back accepts.
//  - Hold: while rsp_valid && !rsp_ready, a writeback to a held rs updates the matching
//    rsp_opN to wb_data on that edge (both operands if rs1==rs2). Other held bits are stable.
//  - Widths: all address compares are full ADSize; no arithmetic beyond init_cnt, which is
//    sized $clog2(REGSize)+1 so it holds REGSize without wrap.
// STRUCTURE
//  - rf_pkg: ADSize/DASize/REGSize defaults and typedef enum logic {INIT, RUN} rf_state_e.
//  - Single module; no sub-module. Forwarding is a local function fwd() used for both ports.
// TESTING
//  1 Init: rst 1 cycle, then 32 cycles -> rf_we=1 with rf_waddr 0..31, rf_din=0;
//    init_done rises at cycle 33; req_ready=0 until then.
//  2 Write/read: wb (rd=1,0x2), (rd=2,0x3) on two cycles, then req rs1=1, rs2=2 ->
//    next cycle rsp_valid=1, op1=0x2, op2=0x3.
//  3 Same-cycle forward: req rs1=3, rs2=3 while wb rd=3 data=0x4 -> op1=op2=0x4.
//  4 Stall: rsp_ready=0 with op1 from rs1=1; wb rd=1 data=0xF -> op1 becomes 0xF, req_ready=0;
//    rsp_ready=1 -> rsp consumed, accept resumes the same cycle.
//  5 ZERO_R0=1: wb rd=0 data=0x1 -> rf_we=0; req rs1=0 -> op1=0. With ZERO_R0=0 -> op1=0x1.
//  6 Reset mid-stall: rsp_valid=1 held, assert rst -> rsp_valid=0 next edge,
//    INIT rewrites all 32 registers.

Source files
------------

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the register-file access controller.
package rf_pkg;

    localparam int AD_SIZE  = 5;
    localparam int REG_SIZE = 32;
    localparam int DA_SIZE  = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Initiator for a 2-read/1-write register file: clears it after reset, then serves
// operand reads with one-cycle latency, forwarding concurrent and stalled writebacks.
module regfile_access_ctrl
    import rf_pkg::*;
#(
    parameter int ADSize  = AD_SIZE,
    parameter int REGSize = REG_SIZE,
    parameter int DASize  = DA_SIZE,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADSize-1:0] req_rs1,
    input  logic [ADSize-1:0] req_rs2,
    input  logic              wb_valid,
    input  logic [ADSize-1:0] wb_rd,
    input  logic [DASize-1:0] wb_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DASize-1:0] rsp_op1,
    output logic [DASize-1:0] rsp_op2,
    output logic              rf_we,
    output logic [ADSize-1:0] rf_raddr1,
    output logic [ADSize-1:0] rf_raddr2,
    output logic [ADSize-1:0] rf_waddr,
    output logic [DASize-1:0] rf_din,
    input  logic [DASize-1:0] rf_out1,
    input  logic [DASize-1:0] rf_out2
);

    localparam int CW = $clog2(REGSize) + 1;

    rf_state_e         state_r;
    rf_state_e         state_nxt_s;
    logic [CW-1:0]     init_cnt_r;
    logic              rsp_valid_r;
    logic [DASize-1:0] rsp_op1_r;
    logic [DASize-1:0] rsp_op2_r;
    logic [ADSize-1:0] rs1_r;
    logic [ADSize-1:0] rs2_r;
    logic              run_s;
    logic              wb_eff_s;
    logic              accept_s;
    logic              hold_s;

    // Operand source selection shared by both read ports.
    function automatic logic [DASize-1:0] fwd(
        input logic [ADSize-1:0] a,
        input logic [DASize-1:0] rf_val,
        input logic              wb_hit,
        input logic [ADSize-1:0] wb_addr,
        input logic [DASize-1:0] wb_val
    );
        logic [DASize-1:0] res;
        if ((ZERO_R0 != 0) && (a == {ADSize{1'b0}})) begin
            res = {DASize{1'b0}};
        end else if (wb_hit && (wb_addr == a)) begin
            res = wb_val;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    assign run_s     = (state_r == RUN);
    // Writes to r0 are discarded when it is hard-wired to zero.
    assign wb_eff_s  = run_s && wb_valid && !((ZERO_R0 != 0) && (wb_rd == {ADSize{1'b0}}));
    assign req_ready = run_s && (!rsp_valid_r || rsp_ready);
    assign accept_s  = req_valid && req_ready;
    assign hold_s    = rsp_valid_r && !rsp_ready;
    assign init_done = run_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_op1   = rsp_op1_r;
    assign rsp_op2   = rsp_op2_r;

    // Next state and register-file port drive.
    always_comb begin
        state_nxt_s = state_r;
        rf_we       = 1'b0;
        rf_waddr    = {ADSize{1'b0}};
        rf_din      = {DASize{1'b0}};
        rf_raddr1   = {ADSize{1'b0}};
        rf_raddr2   = {ADSize{1'b0}};
        case (state_r)
            INIT: begin
                rf_we    = 1'b1;
                rf_waddr = ADSize'(init_cnt_r);
                if (init_cnt_r == CW'(REGSize - 1)) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            RUN: begin
                rf_we       = wb_eff_s;
                rf_waddr    = wb_rd;
                rf_din      = wb_data;
                rf_raddr1   = req_rs1;
                rf_raddr2   = req_rs2;
                state_nxt_s = RUN;
            end
            default: begin
                state_nxt_s = INIT;
            end
        endcase
    end

    // FSM state and clear-sequence counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= INIT;
            init_cnt_r <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == INIT) begin
                init_cnt_r <= init_cnt_r + CW'(1);
            end else begin
                init_cnt_r <= init_cnt_r;
            end
        end
    end

    // Response register: capture on accept, refresh held operands from writebacks.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_op1_r   <= {DASize{1'b0}};
            rsp_op2_r   <= {DASize{1'b0}};
            rs1_r       <= {ADSize{1'b0}};
            rs2_r       <= {ADSize{1'b0}};
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_op1_r   <= fwd(req_rs1, rf_out1, wb_eff_s, wb_rd, wb_data);
            rsp_op2_r   <= fwd(req_rs2, rf_out2, wb_eff_s, wb_rd, wb_data);
            rs1_r       <= req_rs1;
            rs2_r       <= req_rs2;
        end else begin
            if (rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
            if (hold_s && wb_eff_s && (wb_rd == rs1_r)) begin
                rsp_op1_r <= wb_data;
            end else begin
                rsp_op1_r <= rsp_op1_r;
            end
            if (hold_s && wb_eff_s && (wb_rd == rs2_r)) begin
                rsp_op2_r <= wb_data;
            end else begin
                rsp_op2_r <= rsp_op2_r;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with behavioural register files attached
// to two instances (r0 ordinary and r0 hard-wired to zero).
module tb_regfile_access_ctrl;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] op1;
        logic [31:0] op2;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rsp_ready;

    logic        init_done_a, req_ready_a, rsp_valid_a, rf_we_a;
    logic [31:0] rsp_op1_a, rsp_op2_a, rf_din_a, rf_out1_a, rf_out2_a;
    logic [4:0]  rf_raddr1_a, rf_raddr2_a, rf_waddr_a;
    logic        init_done_b, req_ready_b, rsp_valid_b, rf_we_b;
    logic [31:0] rsp_op1_b, rsp_op2_b, rf_din_b, rf_out1_b, rf_out2_b;
    logic [4:0]  rf_raddr1_b, rf_raddr2_b, rf_waddr_b;

    logic [31:0] mem_a [0:31];
    logic [31:0] mem_b [0:31];
    logic [31:0] ref_regs [0:31];

    exp_t q[$];
    logic exp_valid;
    logic running;
    int   total;
    int   bad;

    regfile_access_ctrl #(.ADSize(5), .REGSize(32), .DASize(32), .ZERO_R0(0)) dut_a (
        .clk(clk), .rst(rst), .init_done(init_done_a),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_op1(rsp_op1_a), .rsp_op2(rsp_op2_a),
        .rf_we(rf_we_a), .rf_raddr1(rf_raddr1_a), .rf_raddr2(rf_raddr2_a), .rf_waddr(rf_waddr_a),
        .rf_din(rf_din_a), .rf_out1(rf_out1_a), .rf_out2(rf_out2_a)
    );

    regfile_access_ctrl #(.ADSize(5), .REGSize(32), .DASize(32), .ZERO_R0(1)) dut_b (
        .clk(clk), .rst(rst), .init_done(init_done_b),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_op1(rsp_op1_b), .rsp_op2(rsp_op2_b),
        .rf_we(rf_we_b), .rf_raddr1(rf_raddr1_b), .rf_raddr2(rf_raddr2_b), .rf_waddr(rf_waddr_b),
        .rf_din(rf_din_b), .rf_out1(rf_out1_b), .rf_out2(rf_out2_b)
    );

    // Behavioural register files: combinational read, write on posedge.
    assign rf_out1_a = mem_a[rf_raddr1_a];
    assign rf_out2_a = mem_a[rf_raddr2_a];
    assign rf_out1_b = mem_b[rf_raddr1_b];
    assign rf_out2_b = mem_b[rf_raddr2_b];

    always @(posedge clk) begin
        if (rf_we_a) mem_a[rf_waddr_a] <= rf_din_a;
        if (rf_we_b) mem_b[rf_waddr_b] <= rf_din_b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] fwd_model(input logic [4:0] a);
        if (wb_valid && (wb_rd == a)) return wb_data;
        return ref_regs[a];
    endfunction

    task automatic set_idle();
        req_valid = 1'b0;
        req_rs1   = 5'd0;
        req_rs2   = 5'd0;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
        rsp_ready = 1'b1;
    endtask

    // One clock cycle of handshake modelling; inputs are already driven by the caller.
    task automatic step();
        exp_t e;
        logic exp_ready;
        logic accept;
        @(negedge clk);
        exp_ready = running && (!exp_valid || rsp_ready);
        check_val("rsp_valid", {31'd0, rsp_valid_a}, {31'd0, exp_valid});
        check_val("req_ready", {31'd0, req_ready_a}, {31'd0, exp_ready});
        if (exp_valid && rsp_ready && (q.size() > 0)) begin
            e = q.pop_front();
            check_val("rsp_op1", rsp_op1_a, e.op1);
            check_val("rsp_op2", rsp_op2_a, e.op2);
        end else if (exp_valid && wb_valid && (q.size() > 0)) begin
            if (q[0].rs1 == wb_rd) q[0].op1 = wb_data;
            if (q[0].rs2 == wb_rd) q[0].op2 = wb_data;
        end
        accept = req_valid && exp_ready;
        if (accept) begin
            e.rs1 = req_rs1;
            e.rs2 = req_rs2;
            e.op1 = fwd_model(req_rs1);
            e.op2 = fwd_model(req_rs2);
            q.push_back(e);
        end
        exp_valid = accept ? 1'b1 : (rsp_ready ? 1'b0 : exp_valid);
        if (running && wb_valid) ref_regs[wb_rd] = wb_data;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse followed by the full clear sequence.
    task automatic reset_and_init();
        set_idle();
        rsp_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        running = 1'b0;
        exp_valid = 1'b0;
        q.delete();
        check_val("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
        check_val("rst_init_done", {31'd0, init_done_a}, 32'd0);
        check_val("rst_rsp_op1", rsp_op1_a, 32'd0);
        check_val("rst_rsp_op2", rsp_op2_a, 32'd0);
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'h0000_0BAD;
        req_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check_val("init_we", {31'd0, rf_we_a}, 32'd1);
            check_val("init_waddr", {27'd0, rf_waddr_a}, 32'(i));
            check_val("init_din", rf_din_a, 32'd0);
            check_val("init_ready", {31'd0, req_ready_a}, 32'd0);
            check_val("init_done_lo", {31'd0, init_done_a}, 32'd0);
            @(posedge clk);
            #1;
        end
        set_idle();
        running = 1'b1;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        check_val("init_done_hi", {31'd0, init_done_a}, 32'd1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        running = 1'b0;
        exp_valid = 1'b0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        reset_and_init();

        // Write two registers, then read them back.
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h2;
        step();
        wb_rd = 5'd2; wb_data = 32'h3;
        step();
        set_idle();
        req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2;
        step();
        set_idle();
        step();

        // Same-cycle forward on both ports.
        req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd3;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h4;
        step();
        set_idle();
        step();

        // Stall with a writeback to the held rs1, then release and accept together.
        req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2; rsp_ready = 1'b0;
        step();
        req_rs1 = 5'd4; wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hF;
        step();
        check_val("stall_op1", rsp_op1_a, 32'hF);
        wb_valid = 1'b0; rsp_ready = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd1;
        step();
        set_idle();
        step();

        // r0 write: dropped only on the hard-wired-zero instance.
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1;
        #1;
        check_val("zr_we_a", {31'd0, rf_we_a}, 32'd1);
        check_val("zr_we_b", {31'd0, rf_we_b}, 32'd0);
        step();
        set_idle();
        req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd1;
        step();
        check_val("zr_op1_b", rsp_op1_b, 32'd0);
        check_val("zr_op2_b", rsp_op2_b, 32'hF);
        set_idle();
        step();

        // Randomised traffic on a small address window.
        for (int n = 0; n < 80; n++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_rs1   = 5'($urandom_range(0, 7));
            req_rs2   = 5'($urandom_range(0, 7));
            wb_valid  = 1'($urandom_range(0, 1));
            wb_rd     = 5'($urandom_range(1, 7));
            wb_data   = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        set_idle();
        step();
        step();
        check_val("drain_empty", 32'(q.size()), 32'd0);

        // Reset while a response is held.
        req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd3; rsp_ready = 1'b0;
        step();
        set_idle();
        rsp_ready = 1'b0;
        step();
        check_val("held_valid", {31'd0, rsp_valid_a}, 32'd1);
        reset_and_init();
        req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd3;
        step();
        set_idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
